// File: rtl/exhaustive_eqv_checker.sv
// Exhaustive equivalence checker: sweeps every input vector into an external DUT and
// compares its response against a loadable truth table. Optional macro: EQV_FAIL_LOG_EN.
module exhaustive_eqv_checker #(
    parameter int                     N_IN    = 4,
    parameter int                     DUT_LAT = 0,
    parameter logic [(1<<N_IN)-1:0]   TT_INIT = 16'h0239
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      tt_load_en,
    input  logic [(1<<N_IN)-1:0]      tt_load_data,
    output logic [N_IN-1:0]           dut_in,
    input  logic                      dut_out,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [N_IN-1:0]           fail_idx,
    output logic [N_IN:0]             fail_cnt
);
    localparam int TT_W = 1 << N_IN;
    localparam int DW   = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              mismatch_q, mismatch_d;
    logic              pass_q, pass_d;
    logic              cmp_valid, cmp_exp, cmp_miss, sweep_go;
`ifdef EQV_FAIL_LOG_EN
    logic [N_IN-1:0]   cmp_idx;
`endif

    // A simultaneous load request takes priority over start.
    assign sweep_go = (state_q == S_IDLE) && start && !tt_load_en;
    assign cmp_miss = cmp_valid && (dut_out != cmp_exp);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tt_d       = tt_q;
        drain_d    = drain_q;
        mismatch_d = mismatch_q | cmp_miss;
        pass_d     = pass_q;
        case (state_q)
            S_IDLE: begin
                if (tt_load_en) begin
                    tt_d = tt_load_data;
                end else if (start) begin
                    state_d    = S_SWEEP;
                    idx_d      = '0;
                    mismatch_d = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            S_SWEEP: begin
                if (&idx_q) begin
                    if (DUT_LAT == 0) begin
                        state_d = S_DONE;
                        pass_d  = ~mismatch_d;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(DUT_LAT - 1)) begin
                    state_d = S_DONE;
                    pass_d  = ~mismatch_d;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tt_q       <= TT_INIT;
            drain_q    <= '0;
            mismatch_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tt_q       <= tt_d;
            drain_q    <= drain_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
        end
    end

    // Expected bits either compare in the same cycle or ride a pipe matching DUT latency.
    generate
        if (DUT_LAT == 0) begin : g_comb
            assign cmp_valid = (state_q == S_SWEEP);
            assign cmp_exp   = tt_q[idx_q];
`ifdef EQV_FAIL_LOG_EN
            assign cmp_idx   = idx_q;
`endif
        end else begin : g_pipe
            logic [DUT_LAT-1:0] vld_q;
            logic [DUT_LAT-1:0] exp_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    exp_q <= '0;
                end else begin
                    vld_q[0] <= (state_q == S_SWEEP);
                    exp_q[0] <= tt_q[idx_q];
                    for (int s = 1; s < DUT_LAT; s++) begin
                        vld_q[s] <= vld_q[s-1];
                        exp_q[s] <= exp_q[s-1];
                    end
                end
            end

            assign cmp_valid = vld_q[DUT_LAT-1];
            assign cmp_exp   = exp_q[DUT_LAT-1];
`ifdef EQV_FAIL_LOG_EN
            logic [N_IN-1:0] pidx_q [DUT_LAT];

            always_ff @(posedge clk) begin
                pidx_q[0] <= idx_q;
                for (int s = 1; s < DUT_LAT; s++) begin
                    pidx_q[s] <= pidx_q[s-1];
                end
            end

            assign cmp_idx = pidx_q[DUT_LAT-1];
`endif
        end
    endgenerate

`ifdef EQV_FAIL_LOG_EN
    logic [N_IN-1:0] fail_idx_q, fail_idx_d;
    logic [N_IN:0]   fail_cnt_q, fail_cnt_d;

    always_comb begin
        fail_idx_d = fail_idx_q;
        fail_cnt_d = fail_cnt_q;
        if (sweep_go) begin
            fail_idx_d = '0;
            fail_cnt_d = '0;
        end else if (cmp_miss) begin
            if (!mismatch_q) begin
                fail_idx_d = cmp_idx;
            end
            fail_cnt_d = fail_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_idx_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            fail_idx_q <= fail_idx_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign fail_idx = fail_idx_q;
    assign fail_cnt = fail_cnt_q;
`else
    assign fail_idx = '0;
    assign fail_cnt = '0;
`endif

    assign dut_in = idx_q;
    assign busy   = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign done   = (state_q == S_DONE);
    assign pass   = pass_q;

endmodule
